// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// controller states and small op-decode helpers.
package mult_div_unit_pkg;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } mduState_e;

  function automatic logic isDivOp(input logic [1:0] mduOp);
    return !(mduOp == MDU_MULT || mduOp == MDU_MULTU);
  endfunction

  function automatic logic isSignedOp(input logic [1:0] mduOp);
    logic s;
    case (mduOp)
      MDU_MULT, MDU_DIV:   s = 1'b1;
      MDU_MULTU, MDU_DIVU: s = 1'b0;
      default:             s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the unsigned engine: shift-add multiply or restoring divide.
// partial = {spare bit, upper half (acc / remainder), lower half (multiplier / quotient)}.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  partial,
  input  logic [WIDTH-1:0]  operand,
  input  logic              isDiv,
  output logic [2*WIDTH:0]  nextPartial
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH:0] shifted;

  // Multiply adds the operand when the current multiplier bit is set, then
  // shifts right; divide shifts the dividend left into the remainder and
  // subtracts the divisor whenever it fits.
  always_comb begin
    sum         = partial[2*WIDTH:WIDTH] + (partial[0] ? {1'b0, operand} : '0);
    shifted     = {partial[2*WIDTH-1:0], 1'b0};
    diff        = shifted[2*WIDTH:WIDTH] - {1'b0, operand};
    nextPartial = {1'b0, sum, partial[WIDTH-1:1]};
    if (isDiv) begin
      if (shifted[2*WIDTH:WIDTH] >= {1'b0, operand})
        nextPartial = {diff, shifted[WIDTH-1:1], 1'b1};
      else
        nextPartial = shifted;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO; also services MTHI/MTLO.
// Works on unsigned magnitudes for WIDTH steps, then applies sign correction.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             hiWe,
  input  logic             loWe,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  mduState_e        state;
  logic [CW-1:0]    counter;
  logic [2*WIDTH:0] partial;
  logic [2*WIDTH:0] nextPartial;
  logic [WIDTH-1:0] magB;
  logic [WIDTH-1:0] rawA;
  logic             opDiv;
  logic             negLo;
  logic             negHi;
  logic             divZero;

  logic             signA;
  logic             signB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magBIn;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fixHi;
  logic [WIDTH-1:0] fixLo;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .partial     (partial),
    .operand     (magB),
    .isDiv       (opDiv),
    .nextPartial (nextPartial)
  );

  // Operand magnitudes; 0x80000000 stays 0x80000000 as an unsigned value.
  always_comb begin
    signA  = isSignedOp(op) & opA[WIDTH-1];
    signB  = isSignedOp(op) & opB[WIDTH-1];
    magA   = signA ? ('0 - opA) : opA;
    magBIn = signB ? ('0 - opB) : opB;
  end

  // Sign correction; divide by zero reports the raw dividend and all-ones.
  always_comb begin
    quot  = partial[WIDTH-1:0];
    rem   = partial[2*WIDTH-1:WIDTH];
    prod  = negLo ? ('0 - partial[2*WIDTH-1:0]) : partial[2*WIDTH-1:0];
    fixHi = prod[2*WIDTH-1:WIDTH];
    fixLo = prod[WIDTH-1:0];
    if (opDiv) begin
      if (divZero) begin
        fixHi = rawA;
        fixLo = '1;
      end else begin
        fixLo = negLo ? ('0 - quot) : quot;
        fixHi = negHi ? ('0 - rem) : rem;
      end
    end
  end

  // Controller: a start in IDLE beats any same-cycle MTHI/MTLO; starts and
  // writes arriving during CALC or FIX are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      counter <= '0;
      partial <= '0;
      magB    <= '0;
      rawA    <= '0;
      opDiv   <= 1'b0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      divZero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            partial <= {1'b0, {WIDTH{1'b0}}, magA};
            magB    <= magBIn;
            rawA    <= opA;
            opDiv   <= isDivOp(op);
            negLo   <= signA ^ signB;
            negHi   <= signA;
            divZero <= isDivOp(op) && (opB == '0);
            counter <= CW'(WIDTH);
            busy    <= 1'b1;
            state   <= CALC;
          end else begin
            if (hiWe) hi <= wdata;
            if (loWe) lo <= wdata;
          end
        end
        CALC: begin
          partial <= nextPartial;
          counter <= counter - 1'b1;
          if (counter == CW'(1)) state <= FIX;
        end
        FIX: begin
          hi    <= fixHi;
          lo    <= fixLo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of ops with hand-computed
// HI/LO plus sequences for ignored issues, MTHI/MTLO and mid-op reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         hiWe;
  logic         loWe;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eHi;
    logic [W-1:0] eLo;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .opA   (opA),
    .opB   (opB),
    .hiWe  (hiWe),
    .loWe  (loWe),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  function automatic vec_t mkVec(input string n, input logic [1:0] o,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] eh, input logic [W-1:0] el);
    vec_t v;
    v.name = n; v.op = o; v.a = a; v.b = b; v.eHi = eh; v.eLo = el;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [1:0] o,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic hw, input logic lw, input logic [W-1:0] wd);
    @(negedge clk);
    start = st; op = o; opA = a; opB = b; hiWe = hw; loWe = lw; wdata = wd;
  endtask

  task automatic clearInputs();
    start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
  endtask

  // Issue one op, count edges to done and check busy, latency and result.
  task automatic runOp(input string name, input logic [1:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eHi, input logic [W-1:0] eLo);
    int n;
    bit seen;
    applyStimulus(1'b1, o, a, b, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    clearInputs();
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 1)  checkOutput({name, " busy_e1"}, W'(busy), W'(1));
      if (n == 32 && !done) checkOutput({name, " busy_e32"}, W'(busy), W'(1));
      if (done) seen = 1;
    end
    checkOutput({name, " latency"}, W'(n), W'(33));
    checkOutput({name, " busy_at_done"}, W'(busy), W'(0));
    checkOutput({name, " hi"}, hi, eHi);
    checkOutput({name, " lo"}, lo, eLo);
    @(posedge clk); #1;
    checkOutput({name, " done_pulse_width"}, W'(done), W'(0));
  endtask

  initial begin
    int n;
    bit seen;

    vecs.push_back(mkVec("multu_max",  MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001));
    vecs.push_back(mkVec("mult_m3x5",  MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1));
    vecs.push_back(mkVec("div_m7d2",   MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD));
    vecs.push_back(mkVec("div_7dm2",   MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD));
    vecs.push_back(mkVec("divu_100d0", MDU_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF));
    vecs.push_back(mkVec("div_m5d0",   MDU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF));
    vecs.push_back(mkVec("div_ovf",    MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000));
    vecs.push_back(mkVec("divu_9d4",   MDU_DIVU,  32'd9,        32'd4,        32'h00000001, 32'h00000002));
    vecs.push_back(mkVec("multu_2p32", MDU_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000));

    reset = 1'b1; start = 1'b0; op = MDU_MULT; opA = '0; opB = '0;
    hiWe = 1'b0; loWe = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", W'(busy), W'(0));
    checkOutput("reset done", W'(done), W'(0));
    checkOutput("reset hi", hi, '0);
    checkOutput("reset lo", lo, '0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i])
      runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eHi, vecs[i].eLo);

    // MTHI then MTLO while idle
    applyStimulus(1'b0, MDU_MULT, '0, '0, 1'b1, 1'b0, 32'h1234);
    @(posedge clk); #1;
    clearInputs();
    checkOutput("mthi hi", hi, 32'h1234);
    applyStimulus(1'b0, MDU_MULT, '0, '0, 1'b0, 1'b1, 32'h5678);
    @(posedge clk); #1;
    clearInputs();
    checkOutput("mtlo lo", lo, 32'h5678);
    checkOutput("mtlo hi_kept", hi, 32'h1234);

    // start with hiWe in the same cycle; a second start+MTHI pulse mid-op
    applyStimulus(1'b1, MDU_DIVU, 32'd9, 32'd4, 1'b1, 1'b0, 32'hFFFF);
    @(posedge clk); #1;
    clearInputs();
    checkOutput("start_wins hi", hi, 32'h1234);
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      clearInputs();
      n++;
      if (n == 20) begin
        checkOutput("calc_hold hi", hi, 32'h1234);
        checkOutput("calc_hold lo", lo, 32'h5678);
      end
      if (done) seen = 1;
      else if (n == 5) begin
        @(negedge clk);
        start = 1'b1; op = MDU_MULTU; opA = 32'd2; opB = 32'd2;
        hiWe = 1'b1; wdata = 32'hAAAA;
      end
    end
    checkOutput("ignored_issue latency", W'(n), W'(33));
    checkOutput("ignored_issue hi", hi, 32'd1);
    checkOutput("ignored_issue lo", lo, 32'd2);
    @(posedge clk); #1;
    checkOutput("ignored_issue no_second_op", W'(busy), W'(0));

    // reset in the middle of a MULT aborts it without a done pulse
    applyStimulus(1'b1, MDU_MULT, 32'd7, 32'd6, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    clearInputs();
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort busy", W'(busy), W'(0));
    checkOutput("abort hi", hi, '0);
    checkOutput("abort lo", lo, '0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    checkOutput("abort no_done", W'(seen), W'(0));

    runOp("mult_7x6", MDU_MULT, 32'd7, 32'd6, 32'd0, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
